fp_csr_unit: RTL and testbench
==============================

// Module: fp_csr_unit
// PURPOSE
//  Owns the RV32F floating-point CSR state (fcsr = {frm[2:0], fflags[4:0]}) and the mstatus.FS dirty-tracking FSM.
//  Upstream of FP_ALU: resolves each instruction's rm field (DYN=3'b111 -> frm) and drives FP_ALU.rm/enable gating.
//  Downstream of FP_ALU: sticky-ORs its fflags output into fflags when an FP op retires.
//  Serves CSR instructions (csrrw/csrrs/csrrc and immediate forms) to fflags 0x001, frm 0x002 and fcsr 0x003.
// PARAMETERS
//  FS_RESET  2'b01  mstatus.FS value after reset (00 Off, 01 Initial, 10 Clean, 11 Dirty)
// PORTS
//  clk           in   1   clock, rising edge
//  rst_n         in   1   asynchronous active-low reset
//  instr_rm      in   3   rm field of the FP instruction in decode
//  fp_instr      in   1   decode holds an FP instruction
//  rm_out        out  3   resolved rounding mode, to FP_ALU.rm
//  fp_enable     out  1   FP_ALU.enable = fp_instr & ~fp_illegal
//  fp_illegal    out  1   illegal-instruction request: FS==Off, or resolved rm is 101/110
//  fp_retire     in   1   an FP op retires this cycle
//  fp_fflags     in   5   FP_ALU fflags {NV,DZ,OF,UF,NX} for the retiring op
//  fp_wr_freg    in   1   retiring op writes the FP register file
//  csr_valid     in   1   CSR access this cycle
//  csr_addr      in   12  CSR address
//  csr_op        in   2   01 write, 10 set, 11 clear; 00 read only
//  csr_wdata     in   32  write / mask operand
//  csr_rdata     out  32  read data, zero-extended
//  csr_hit       out  1   csr_valid & address is 0x001/0x002/0x003
//  fs_wr_en      in   1   mstatus write from the privileged CSR block
//  fs_wdata      in   2   new FS value
//  fs_state      out  2   current FS value
// BEHAVIOUR
//  Reset: frm=0, fflags=0, fs_state=FS_RESET.
//  - All outputs are combinational from registers and inputs.
//  - With csr_valid=0 and fp_instr=0: csr_rdata=0, csr_hit=0, fp_enable=0, fp_illegal=0.
//  rm resolution: rm_out = (instr_rm==3'b111) ? frm : instr_rm.
//  - fp_illegal = fp_instr & (fs_state==00 | rm_out==101 | rm_out==110).
//  - If frm holds a reserved code, every DYN instruction is illegal.
//  Accrual: acc = fflags | (fp_retire ? fp_fflags : 0).
//  - acc is the base for both the CSR read and the CSR op in the same cycle.
//  - The retiring FP op is older than the CSR instruction, so its flags apply first.
//  CSR read: csr_rdata is only valid when csr_hit:
//  - 0x001 -> {27'b0, acc}
//  - 0x002 -> {29'b0, frm}
//  - 0x003 -> {24'b0, frm, acc}
//  CSR update: applied at the next clock edge, only when csr_hit and csr_op!=00.
//  - write: new = wdata
//  - set:   new = old | wdata
//  - clear: new = old & ~wdata
//  - Only bits [4:0] (fflags), [2:0] (frm) or [7:0] (fcsr) are used; higher wdata bits are ignored.
//  - When there is no CSR update, fflags <= acc.
//  - csr_op==00 with csr_hit: read only, no write; accrual still happens.
//  FS FSM, states Off/Initial/Clean/Dirty:
//  - fs_wr_en loads fs_wdata. It has highest priority, so a Dirty transition in the same cycle is discarded.
//  - Otherwise the state goes to Dirty (from Initial or Clean) on any of:
//    - a CSR update (csr_hit & csr_op!=00), or
//    - fp_retire & (fp_wr_freg | fp_fflags!=0).
//  - Off stays Off. Dirty stays Dirty until fs_wr_en.
//  - No CSR update (and no FS transition) occurs while fs_state==Off; csr_rdata still reads as normal.
//  Reset asserted mid-operation: all state is cleared immediately; any pending accrual or CSR write is lost.
//  Latency: update visible one cycle after the access; reads see same-cycle accrual.
// TESTING
//  1. Reset -> fcsr=0x00, fs_state=01, csr_rdata(0x003)=0.
//  2. Write frm 0x002 = 3'b010. Then instr_rm=111 -> rm_out=010.
//     Then write frm = 3'b101 with a DYN instruction -> fp_illegal=1, fp_enable=0.
//  3. fp_retire with fflags=00001, then 10000 -> fflags=10001. Read of 0x001 in the next cycle = 0x11.
//  4. Same cycle: fp_retire fflags=00100 and csrrc 0x001 mask 0x04 -> rdata=0x04, fflags=0 afterwards.
//  5. fs_wdata=10 (Clean). A csrrs to fcsr with mask 0 -> Dirty (11).
//     Same-cycle fs_wr_en=10 with a retiring op -> Clean.
//  6. FS=00 (Off): fp_instr -> fp_illegal=1. A CSR write to 0x003 leaves fcsr unchanged.
//     Assert rst_n low mid-write -> fcsr=0 immediately.

Source files
------------

// File: rtl/fp_csr_unit.sv
// fp_csr_unit: RV32F floating-point CSR state (frm, fflags) and mstatus.FS tracking.
// Resolves dynamic rounding mode for the FP ALU, gates illegal FP instructions,
// accrues exception flags from retiring FP ops and serves fflags/frm/fcsr accesses.
module fp_csr_unit #(
   parameter logic [1:0] FS_RESET = 2'b01
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [2:0]  instr_rm,
   input  logic        fp_instr,
   output logic [2:0]  rm_out,
   output logic        fp_enable,
   output logic        fp_illegal,
   input  logic        fp_retire,
   input  logic [4:0]  fp_fflags,
   input  logic        fp_wr_freg,
   input  logic        csr_valid,
   input  logic [11:0] csr_addr,
   input  logic [1:0]  csr_op,
   input  logic [31:0] csr_wdata,
   output logic [31:0] csr_rdata,
   output logic        csr_hit,
   input  logic        fs_wr_en,
   input  logic [1:0]  fs_wdata,
   output logic [1:0]  fs_state
);

   typedef enum logic [1:0] {
      FS_OFF   = 2'b00,
      FS_INIT  = 2'b01,
      FS_CLEAN = 2'b10,
      FS_DIRTY = 2'b11
   } fs_t;

   localparam logic [11:0] ADDR_FFLAGS = 12'h001;
   localparam logic [11:0] ADDR_FRM    = 12'h002;
   localparam logic [11:0] ADDR_FCSR   = 12'h003;

   localparam logic [2:0] RM_DYN = 3'b111;
   localparam logic [2:0] RM_RSV5 = 3'b101;
   localparam logic [2:0] RM_RSV6 = 3'b110;

   logic [2:0] frm_r;
   logic [4:0] fflags_r;
   fs_t        fs_r;

   logic [4:0] acc;
   logic [7:0] csr_old;
   logic [7:0] csr_new;
   logic       csr_upd;
   logic       fp_dirty;
   logic       unused_wdata;

   // Read-modify-write for csrrw / csrrs / csrrc on an 8-bit CSR view
   function automatic logic [7:0] csr_apply(input logic [1:0] op,
                                            input logic [7:0] old_val,
                                            input logic [7:0] wdata);
      logic [7:0] res;
      case (op)
         2'b01:   res = wdata;
         2'b10:   res = old_val | wdata;
         2'b11:   res = old_val & ~wdata;
         default: res = old_val;
      endcase
      return res;
   endfunction

   // Only the low byte of the operand reaches any of the three CSRs
   assign unused_wdata = ^csr_wdata[31:8];

   // Rounding-mode resolution and illegal-instruction gating for decode
   always_comb begin
      rm_out     = (instr_rm == RM_DYN) ? frm_r : instr_rm;
      fp_illegal = fp_instr & ((fs_r == FS_OFF) | (rm_out == RM_RSV5) | (rm_out == RM_RSV6));
      fp_enable  = fp_instr & ~fp_illegal;
   end

   // Flag accrual and CSR read/update decode; the retiring op's flags are applied first
   always_comb begin
      acc     = fflags_r | (fp_retire ? fp_fflags : 5'b0);
      csr_hit = csr_valid & ((csr_addr == ADDR_FFLAGS) | (csr_addr == ADDR_FRM) |
                             (csr_addr == ADDR_FCSR));
      case (csr_addr)
         ADDR_FFLAGS: csr_old = {3'b0, acc};
         ADDR_FRM:    csr_old = {5'b0, frm_r};
         ADDR_FCSR:   csr_old = {frm_r, acc};
         default:     csr_old = 8'b0;
      endcase
      csr_rdata = csr_hit ? {24'b0, csr_old} : 32'b0;
      csr_new   = csr_apply(csr_op, csr_old, csr_wdata[7:0]);
      csr_upd   = csr_hit & (csr_op != 2'b00) & (fs_r != FS_OFF);
      fp_dirty  = fp_retire & (fp_wr_freg | (fp_fflags != 5'b0));
      fs_state  = fs_r;
   end

   // frm / fflags state: CSR update wins over plain accrual
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         frm_r    <= 3'b0;
         fflags_r <= 5'b0;
      end else begin
         fflags_r <= acc;
         if (csr_upd) begin
            case (csr_addr)
               ADDR_FFLAGS: fflags_r <= csr_new[4:0];
               ADDR_FRM:    frm_r    <= csr_new[2:0];
               ADDR_FCSR: begin
                  frm_r    <= csr_new[7:5];
                  fflags_r <= csr_new[4:0];
               end
               default: ;
            endcase
         end
      end
   end

   // mstatus.FS tracking: privileged write has priority over the Dirty transition
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fs_r <= fs_t'(FS_RESET);
      end else if (fs_wr_en) begin
         fs_r <= fs_t'(fs_wdata);
      end else begin
         case (fs_r)
            FS_INIT, FS_CLEAN: if (csr_upd | fp_dirty) fs_r <= FS_DIRTY;
            default:           fs_r <= fs_r;
         endcase
      end
   end

endmodule

// File: tb/tb_fp_csr_unit.sv
// Scoreboard bench for fp_csr_unit: directed scenarios then randomized traffic,
// checked against a byte-wide fcsr reference model.
module tb_fp_csr_unit;

   localparam logic [1:0] FS_RESET = 2'b01;

   logic        clk;
   logic        rst_n;
   logic [2:0]  instr_rm;
   logic        fp_instr;
   logic [2:0]  rm_out;
   logic        fp_enable;
   logic        fp_illegal;
   logic        fp_retire;
   logic [4:0]  fp_fflags;
   logic        fp_wr_freg;
   logic        csr_valid;
   logic [11:0] csr_addr;
   logic [1:0]  csr_op;
   logic [31:0] csr_wdata;
   logic [31:0] csr_rdata;
   logic        csr_hit;
   logic        fs_wr_en;
   logic [1:0]  fs_wdata;
   logic [1:0]  fs_state;

   fp_csr_unit #(.FS_RESET(FS_RESET)) dut (
      .clk(clk), .rst_n(rst_n),
      .instr_rm(instr_rm), .fp_instr(fp_instr),
      .rm_out(rm_out), .fp_enable(fp_enable), .fp_illegal(fp_illegal),
      .fp_retire(fp_retire), .fp_fflags(fp_fflags), .fp_wr_freg(fp_wr_freg),
      .csr_valid(csr_valid), .csr_addr(csr_addr), .csr_op(csr_op),
      .csr_wdata(csr_wdata), .csr_rdata(csr_rdata), .csr_hit(csr_hit),
      .fs_wr_en(fs_wr_en), .fs_wdata(fs_wdata), .fs_state(fs_state)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      int          id;
      logic [2:0]  rm;
      logic        en;
      logic        ill;
      logic [31:0] rdata;
      logic        hit;
      logic [1:0]  fs;
   } exp_t;

   exp_t sb[$];
   int   n_chk  = 0;
   int   n_fail = 0;
   int   step_id = 0;

   // staged stimulus for the next cycle
   logic [2:0]  s_rm;
   logic        s_fpi, s_ret, s_wrf, s_cv, s_fswe;
   logic [4:0]  s_ff;
   logic [11:0] s_addr;
   logic [1:0]  s_op, s_fswd;
   logic [31:0] s_wd;

   // reference model: fcsr kept as one byte {frm, fflags}
   logic [7:0] m_fcsr;
   logic [1:0] m_fs;

   task automatic chk(input string nm, input int id, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s step %0d: got %0h expected %0h", nm, id, act, exp);
      end
   endtask

   task automatic idle();
      s_rm = 3'b000; s_fpi = 1'b0; s_ret = 1'b0; s_ff = 5'b0; s_wrf = 1'b0;
      s_cv = 1'b0; s_addr = 12'h000; s_op = 2'b00; s_wd = 32'b0;
      s_fswe = 1'b0; s_fswd = 2'b00;
   endtask

   // Drive one cycle of stimulus, push the expected response, advance the model
   task automatic apply(input bit mid_reset);
      exp_t        e;
      logic [7:0]  acc8, mask;
      int          sh;
      logic [31:0] view, nv;
      logic        upd, dirty;
      @(posedge clk);
      #1;
      rst_n      = 1'b1;
      instr_rm   = s_rm;   fp_instr  = s_fpi;
      fp_retire  = s_ret;  fp_fflags = s_ff;   fp_wr_freg = s_wrf;
      csr_valid  = s_cv;   csr_addr  = s_addr; csr_op = s_op; csr_wdata = s_wd;
      fs_wr_en   = s_fswe; fs_wdata  = s_fswd;
      if (mid_reset) begin
         #2;
         rst_n  = 1'b0;
         m_fcsr = 8'h00;
         m_fs   = FS_RESET;
      end
      acc8  = m_fcsr | {3'b0, (s_ret ? s_ff : 5'b0)};
      e.rm  = (s_rm == 3'b111) ? m_fcsr[7:5] : s_rm;
      e.ill = s_fpi && (m_fs == 2'b00 || e.rm == 3'd5 || e.rm == 3'd6);
      e.en  = s_fpi && !e.ill;
      case (s_addr)
         12'h001: begin mask = 8'h1F; sh = 0; end
         12'h002: begin mask = 8'hE0; sh = 5; end
         12'h003: begin mask = 8'hFF; sh = 0; end
         default: begin mask = 8'h00; sh = 0; end
      endcase
      e.hit   = s_cv && (s_addr == 12'h001 || s_addr == 12'h002 || s_addr == 12'h003);
      view    = {24'b0, acc8 & mask} >> sh;
      e.rdata = e.hit ? view : 32'b0;
      e.fs    = m_fs;
      e.id    = step_id;
      sb.push_back(e);
      step_id++;
      if (!mid_reset) begin
         upd = e.hit && (s_op != 2'b00) && (m_fs != 2'b00);
         case (s_op)
            2'b01:   nv = s_wd;
            2'b10:   nv = view | s_wd;
            2'b11:   nv = view & ~s_wd;
            default: nv = view;
         endcase
         m_fcsr = upd ? ((acc8 & ~mask) | ((nv[7:0] << sh) & mask)) : acc8;
         dirty  = upd || (s_ret && (s_wrf || s_ff != 5'b0));
         if (s_fswe)                                      m_fs = s_fswd;
         else if ((m_fs == 2'b01 || m_fs == 2'b10) && dirty) m_fs = 2'b11;
      end
   endtask

   // Monitor: compare every presented response against the queued expectation
   initial begin
      forever begin
         @(negedge clk);
         if (sb.size() != 0) begin
            exp_t e;
            e = sb.pop_front();
            chk("rm_out",     e.id, {29'b0, rm_out},   {29'b0, e.rm});
            chk("fp_enable",  e.id, {31'b0, fp_enable}, {31'b0, e.en});
            chk("fp_illegal", e.id, {31'b0, fp_illegal}, {31'b0, e.ill});
            chk("csr_hit",    e.id, {31'b0, csr_hit},  {31'b0, e.hit});
            chk("csr_rdata",  e.id, csr_rdata,          e.rdata);
            chk("fs_state",   e.id, {30'b0, fs_state}, {30'b0, e.fs});
         end
      end
   end

   initial begin
      rst_n = 1'b0;
      instr_rm = 3'b0; fp_instr = 1'b0; fp_retire = 1'b0; fp_fflags = 5'b0;
      fp_wr_freg = 1'b0; csr_valid = 1'b0; csr_addr = 12'h0; csr_op = 2'b0;
      csr_wdata = 32'b0; fs_wr_en = 1'b0; fs_wdata = 2'b0;
      m_fcsr = 8'h00;
      m_fs   = FS_RESET;
      idle();
      @(posedge clk);

      // reset state: fcsr reads zero, FS Initial
      idle(); s_cv = 1'b1; s_addr = 12'h003; apply(0);
      idle(); apply(0);

      // frm write then DYN resolution, then reserved frm makes DYN illegal
      idle(); s_cv = 1'b1; s_addr = 12'h002; s_op = 2'b01; s_wd = 32'h2; apply(0);
      idle(); s_fpi = 1'b1; s_rm = 3'b111; apply(0);
      idle(); s_cv = 1'b1; s_addr = 12'h002; s_op = 2'b01; s_wd = 32'hFFFF_FFF5; apply(0);
      idle(); s_fpi = 1'b1; s_rm = 3'b111; apply(0);
      idle(); s_fpi = 1'b1; s_rm = 3'b110; apply(0);
      idle(); s_fpi = 1'b1; s_rm = 3'b001; s_cv = 1'b1; s_addr = 12'h002; apply(0);

      // sticky accrual
      idle(); s_ret = 1'b1; s_ff = 5'b00001; apply(0);
      idle(); s_ret = 1'b1; s_ff = 5'b10000; apply(0);
      idle(); s_cv = 1'b1; s_addr = 12'h001; apply(0);

      // same-cycle accrual and clear
      idle(); s_cv = 1'b1; s_addr = 12'h001; s_op = 2'b01; s_wd = 32'h0; apply(0);
      idle(); s_ret = 1'b1; s_ff = 5'b00100; s_cv = 1'b1; s_addr = 12'h001;
      s_op = 2'b11; s_wd = 32'h4; apply(0);
      idle(); s_cv = 1'b1; s_addr = 12'h003; apply(0);

      // FS Clean -> Dirty via csrrs mask 0; fs_wr_en beats a retiring op
      idle(); s_fswe = 1'b1; s_fswd = 2'b10; apply(0);
      idle(); s_cv = 1'b1; s_addr = 12'h003; s_op = 2'b10; s_wd = 32'h0; apply(0);
      idle(); s_fswe = 1'b1; s_fswd = 2'b10; s_ret = 1'b1; s_wrf = 1'b1; apply(0);
      idle(); s_cv = 1'b1; s_addr = 12'h001; s_op = 2'b00; apply(0);
      idle(); s_ret = 1'b1; s_wrf = 1'b1; apply(0);
      idle(); apply(0);

      // FS Off: FP instructions illegal, CSR writes ignored, reads normal
      idle(); s_fswe = 1'b1; s_fswd = 2'b00; apply(0);
      idle(); s_fpi = 1'b1; s_rm = 3'b000; apply(0);
      idle(); s_cv = 1'b1; s_addr = 12'h003; s_op = 2'b01; s_wd = 32'hA5; apply(0);
      idle(); s_cv = 1'b1; s_addr = 12'h003; apply(0);

      // reset asserted in the middle of a write
      idle(); s_fswe = 1'b1; s_fswd = 2'b01; apply(0);
      idle(); s_cv = 1'b1; s_addr = 12'h003; s_op = 2'b01; s_wd = 32'hE7; apply(0);
      idle(); s_cv = 1'b1; s_addr = 12'h003; s_op = 2'b01; s_wd = 32'h5A; apply(1);
      idle(); s_cv = 1'b1; s_addr = 12'h003; apply(0);

      // randomized traffic
      for (int i = 0; i < 400; i++) begin
         s_rm   = 3'($urandom_range(0, 7));
         s_fpi  = 1'($urandom_range(0, 1));
         s_ret  = 1'($urandom_range(0, 1));
         s_ff   = ($urandom_range(0, 2) == 0) ? 5'b0 : 5'($urandom);
         s_wrf  = 1'($urandom_range(0, 1));
         s_cv   = 1'($urandom_range(0, 1));
         case ($urandom_range(0, 5))
            0:       s_addr = 12'h001;
            1:       s_addr = 12'h002;
            2, 3:    s_addr = 12'h003;
            4:       s_addr = 12'h300;
            default: s_addr = 12'($urandom);
         endcase
         s_op   = 2'($urandom_range(0, 3));
         s_wd   = $urandom;
         s_fswe = ($urandom_range(0, 11) == 0);
         s_fswd = 2'($urandom_range(0, 3));
         apply(0);
      end

      idle();
      @(posedge clk);
      @(negedge clk);
      #1;
      chk("sb_drained", step_id, sb.size(), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
